// File: rtl/reg_bank_writer.sv
// rtl/reg_bank_writer.sv - write side of the A/B/C/D register set: one-entry pending stage, commit of load/inc/dec/clr
module reg_bank_writer #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_sel,
  input  logic [1:0]       wr_op,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             freeze,
  output logic [WIDTH-1:0] Aout,
  output logic [WIDTH-1:0] Bout,
  output logic [WIDTH-1:0] Cout,
  output logic [WIDTH-1:0] Dout,
  output logic             done,
  output logic [1:0]       done_sel,
  output logic             wrap
);

  typedef enum logic [1:0] {OP_LOAD, OP_INC, OP_DEC, OP_CLR} op_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONE = '1;

  logic             pend_valid;
  logic [1:0]       pend_sel;
  op_t              pend_op;
  logic [WIDTH-1:0] pend_data;
  logic [WIDTH-1:0] regs [4];

  logic             accept;
  logic             commit;
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] next_val;
  logic             next_wrap;

  // A full pending stage can still take a new request when it commits on the same edge.
  assign wr_ready = !pend_valid || !freeze;
  assign accept   = wr_valid && wr_ready;
  assign commit   = pend_valid && !freeze;
  assign cur_val  = regs[pend_sel];

  always_comb begin
    next_val  = cur_val;
    next_wrap = 1'b0;
    case (pend_op)
      OP_LOAD: next_val = pend_data;
      OP_INC: begin
        next_val  = cur_val + ONE;
        next_wrap = (cur_val == ALL_ONE);
      end
      OP_DEC: begin
        next_val  = cur_val - ONE;
        next_wrap = (cur_val == '0);
      end
      OP_CLR: next_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_sel   <= 2'd0;
      pend_op    <= OP_LOAD;
      pend_data  <= '0;
      done       <= 1'b0;
      done_sel   <= 2'd0;
      wrap       <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= RST_VAL;
    end else begin
      if (accept) begin
        pend_valid <= 1'b1;
        pend_sel   <= wr_sel;
        pend_op    <= op_t'(wr_op);
        pend_data  <= wr_data;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      done     <= commit;
      done_sel <= commit ? pend_sel : 2'd0;
      wrap     <= commit && next_wrap;
      if (commit) regs[pend_sel] <= next_val;
    end
  end

  assign Aout = regs[0];
  assign Bout = regs[1];
  assign Cout = regs[2];
  assign Dout = regs[3];

endmodule

// File: doc/reg_bank_writer.md
Name: reg_bank_writer

Overview:
- Write side of the A/B/C/D 8-bit register set whose outputs feed the 4:1 read mux (Ain..Din, select reg_sel).
- Accepts write requests over a valid/ready handshake and queues them in a one-entry pending stage.
- Commits each request the following cycle as load, increment, decrement or clear of the selected register.
- A freeze input stalls commits, so back-pressure is real.

Parameters:
- WIDTH, 8, register and data width in bits.
- RST_VAL, 0, value loaded into all four registers on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_valid  input  1  request present.
- wr_ready  output  1  block can accept a request this cycle.
- wr_sel  input  2  target register: 0=A, 1=B, 2=C, 3=D.
- wr_op  input  2  operation: 0=LOAD, 1=INC, 2=DEC, 3=CLR.
- wr_data  input  WIDTH  operand for LOAD; ignored otherwise.
- freeze  input  1  when 1, no commit occurs.
- Aout, Bout, Cout, Dout  output  WIDTH  current register contents; these drive the read mux.
- done  output  1  one-cycle pulse, asserted the cycle after a commit.
- done_sel  output  2  register committed, valid while done=1.
- wrap  output  1  one-cycle pulse with done when an INC wrapped max->0 or a DEC wrapped 0->max.

Behaviour:
- Reset (async, rst_n=0): Aout..Dout=RST_VAL, pend_valid=0, done=0, done_sel=0, wrap=0. wr_ready=1 immediately after release.
- Pending stage holds sel, op, data and pend_valid.
- Handshake:
  - wr_ready = !pend_valid | !freeze (combinational).
  - Accept when wr_valid & wr_ready.
  - Inputs are sampled only on accept; wr_valid without wr_ready has no effect, and the requester must hold the request.
- Commit: occurs on a rising edge when pend_valid & !freeze. Register R=sel is updated:
  - LOAD: R<=data.
  - INC: R<=R+1, mod 2^WIDTH.
  - DEC: R<=R-1, mod 2^WIDTH.
  - CLR: R<=0.
- Other registers are unchanged.
- Result is visible on the output one cycle after commit; done/done_sel/wrap register at the commit edge.
- Latency: accept at edge N, commit at edge N+1 (freeze=0), Xout updated after N+1, done high in cycle N+1..N+2.
- Throughput: one request per cycle when freeze=0.
- Simultaneous accept and commit on the same edge: the pending stage is overwritten by the new request, and pend_valid stays 1.
- Commit without accept: pend_valid<=0.
- Back-to-back INC on the same register: the second commit operates on the already-updated value, so no lost update. Two INCs on A from 5 give 7.
- freeze=1 with pend_valid=1:
  - Pending entry is held unchanged and wr_ready=0.
  - done=0 each frozen cycle.
  - Commit happens on the first edge with freeze=0.
- freeze=1 with pend_valid=0: one request may still be accepted (ready=1), then ready drops.
- wrap:
  - Set only for INC from 2^WIDTH-1 or DEC from 0.
  - Never set for LOAD or CLR.
- done, done_sel and wrap return to 0 on any edge without a commit.
- Reset mid-operation: the pending request is discarded, with no commit; all registers return to RST_VAL.
- Xout never changes except through a commit or reset; there are no combinational paths from wr_* to Xout.

Test Plan:
- Reset, then LOAD A=218, B=235, C=93, D=29 on consecutive cycles (freeze=0) -> wr_ready stays 1; Aout..Dout = 218/235/93/29 one cycle after each commit; done_sel = 0,1,2,3.
- Hazard: B=0xFF, then INC B, INC B back-to-back -> Bout=0x00 with wrap=1 on the first done, then Bout=0x01 with wrap=0.
- Back-pressure: freeze=1, offer LOAD C=47 then LOAD D=177 -> first accepted, then wr_ready=0 and D request held; Cout and Dout unchanged, done=0. Release freeze -> Cout=47 next cycle, then Dout=177.
- DEC D=0 -> Dout=255 and wrap=1. CLR D -> Dout=0, wrap=0. LOAD with wr_valid=0 -> no change.
- Async reset while LOAD A=122 is pending -> outputs go to RST_VAL without waiting for clk; no done pulse; the request is never committed after release.
- Random 1000 requests with random freeze, against a scoreboard model -> register values, done/done_sel/wrap and wr_ready match every cycle.
